// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared hold-bus codes, controller state encoding and sizing helper.
// Hold codes are cumulative masks: a consumer tests (hold_flag & HOLD_X) == HOLD_X.
package pipe_hold_ctrl_pkg;

  localparam logic [2:0] HOLD_NONE = 3'b000;
  localparam logic [2:0] HOLD_PC   = 3'b001;
  localparam logic [2:0] HOLD_IF   = 3'b011;
  localparam logic [2:0] HOLD_ID   = 3'b111;

  typedef enum logic [1:0] {
    CTRL_IDLE      = 2'd0,
    CTRL_FLUSH     = 2'd1,
    CTRL_INT_DRAIN = 2'd2,
    CTRL_DIV_WAIT  = 2'd3
  } ctrl_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush scheduler: arbitrates jump, interrupt, divide and bus stalls.
// Ports: clk, rst (sync, high); ex/div/bus/int requests in; hold_flag, jump_flag/addr, int_ack, div_timeout, busy out.
module pipe_hold_ctrl
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int INT_DRAIN    = 2,
  parameter int DIV_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_jump_req,
  input  logic [31:0] ex_jump_addr,
  input  logic        div_start,
  input  logic        div_ready,
  input  logic        bus_hold_req,
  input  logic        int_req,
  input  logic [31:0] int_addr,
  output logic [2:0]  hold_flag,
  output logic        jump_flag,
  output logic [31:0] jump_addr,
  output logic        int_ack,
  output logic        div_timeout,
  output logic        busy
);

  localparam int CW =
    $clog2(max3(FLUSH_CYCLES, INT_DRAIN, DIV_TIMEOUT) + 1);

  localparam bit LONG_FLUSH = (FLUSH_CYCLES > 1);

  localparam logic [CW-1:0] FLUSH_LOAD =
    CW'(LONG_FLUSH ? FLUSH_CYCLES - 2 : 0);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(INT_DRAIN - 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV_TIMEOUT - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);

  ctrl_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CTRL_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      CTRL_IDLE: begin
        if (ex_jump_req) begin
          if (LONG_FLUSH) begin
            state_n = CTRL_FLUSH;
            cnt_n   = FLUSH_LOAD;
          end
        end else if (int_req) begin
          state_n = CTRL_INT_DRAIN;
          cnt_n   = DRAIN_LOAD;
        end else if (div_start) begin
          // a same-cycle result means no wait at all
          if (!div_ready) begin
            state_n = CTRL_DIV_WAIT;
            cnt_n   = '0;
          end
        end
      end
      CTRL_FLUSH: begin
        if (cnt == '0) state_n = CTRL_IDLE;
        else           cnt_n   = cnt - ONE;
      end
      CTRL_INT_DRAIN: begin
        if (cnt == '0) begin
          if (LONG_FLUSH) begin
            state_n = CTRL_FLUSH;
            cnt_n   = FLUSH_LOAD;
          end else begin
            state_n = CTRL_IDLE;
          end
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      CTRL_DIV_WAIT: begin
        if (div_ready)            state_n = CTRL_IDLE;
        else if (cnt == DIV_LAST) state_n = CTRL_IDLE;
        else                      cnt_n   = cnt + ONE;
      end
      default: state_n = CTRL_IDLE;
    endcase
  end

  always_comb begin
    hold_flag   = HOLD_NONE;
    jump_flag   = 1'b0;
    jump_addr   = '0;
    int_ack     = 1'b0;
    div_timeout = 1'b0;
    busy        = 1'b0;
    if (!rst) begin
      busy = (state != CTRL_IDLE);
      case (state)
        CTRL_IDLE: begin
          if (ex_jump_req) begin
            hold_flag = HOLD_ID;
            jump_flag = 1'b1;
            jump_addr = ex_jump_addr;
          end else if (int_req || div_start) begin
            hold_flag = HOLD_ID;
          end else if (bus_hold_req) begin
            hold_flag = HOLD_IF;
          end
        end
        CTRL_FLUSH: hold_flag = HOLD_ID;
        CTRL_INT_DRAIN: begin
          hold_flag = HOLD_ID;
          if (cnt == '0) begin
            jump_flag = 1'b1;
            jump_addr = int_addr;
            int_ack   = 1'b1;
          end
        end
        CTRL_DIV_WAIT: begin
          hold_flag   = HOLD_ID;
          div_timeout = !div_ready && (cnt == DIV_LAST);
        end
        default: hold_flag = HOLD_NONE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Self-checking bench for pipe_hold_ctrl (FLUSH_CYCLES=2, INT_DRAIN=2, DIV_TIMEOUT=64).
// Vector table through a scoreboard queue, plus a hand-written interrupt sequence.
module tb_pipe_hold_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_jump_req;
  logic [31:0] ex_jump_addr;
  logic        div_start;
  logic        div_ready;
  logic        bus_hold_req;
  logic        int_req;
  logic [31:0] int_addr;
  logic [2:0]  hold_flag;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        int_ack;
  logic        div_timeout;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hold_ctrl #(
    .FLUSH_CYCLES(2),
    .INT_DRAIN   (2),
    .DIV_TIMEOUT (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_jump_req (ex_jump_req),
    .ex_jump_addr(ex_jump_addr),
    .div_start   (div_start),
    .div_ready   (div_ready),
    .bus_hold_req(bus_hold_req),
    .int_req     (int_req),
    .int_addr    (int_addr),
    .hold_flag   (hold_flag),
    .jump_flag   (jump_flag),
    .jump_addr   (jump_addr),
    .int_ack     (int_ack),
    .div_timeout (div_timeout),
    .busy        (busy)
  );

  typedef struct {
    logic        rst;
    logic        jr;
    logic [31:0] ja;
    logic        ds;
    logic        dr;
    logic        bh;
    logic        ir;
    logic [31:0] ia;
    logic [2:0]  e_hold;
    logic        e_jf;
    logic [31:0] e_ja;
    logic        e_ack;
    logic        e_tmo;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(
    input logic rst_i, input logic jr, input logic [31:0] ja,
    input logic ds, input logic dr, input logic bh,
    input logic ir, input logic [31:0] ia,
    input logic [2:0] eh, input logic ejf, input logic [31:0] eja,
    input logic eack, input logic etmo, input logic ebusy);
    vec_t v;
    v.rst = rst_i; v.jr = jr; v.ja = ja;
    v.ds = ds; v.dr = dr; v.bh = bh;
    v.ir = ir; v.ia = ia;
    v.e_hold = eh; v.e_jf = ejf; v.e_ja = eja;
    v.e_ack = eack; v.e_tmo = etmo; v.e_busy = ebusy;
    return v;
  endfunction

  // idle-input row with expected hold/busy only
  function automatic vec_t q(input logic [2:0] eh, input logic eb);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, eh, 0, 0, 0, 0, eb);
  endfunction

  task automatic drive(input vec_t v);
    rst          = v.rst;
    ex_jump_req  = v.jr;
    ex_jump_addr = v.ja;
    div_start    = v.ds;
    div_ready    = v.dr;
    bus_hold_req = v.bh;
    int_req      = v.ir;
    int_addr     = v.ia;
  endtask

  task automatic check_row(input int idx, input vec_t e);
    checks++;
    if (hold_flag !== e.e_hold || jump_flag !== e.e_jf ||
        jump_addr !== e.e_ja || int_ack !== e.e_ack ||
        div_timeout !== e.e_tmo || busy !== e.e_busy) begin
      failures++;
      $display("FAIL row%0d: got hold=%b jf=%b ja=%h ack=%b tmo=%b busy=%b want hold=%b jf=%b ja=%h ack=%b tmo=%b busy=%b",
               idx, hold_flag, jump_flag, jump_addr, int_ack,
               div_timeout, busy, e.e_hold, e.e_jf, e.e_ja,
               e.e_ack, e.e_tmo, e.e_busy);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    vec_t v, e;
    int   n;
    bit   seen;

    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // reset, then reset asserted mid DIV_WAIT
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 3'b111, 0, 0, 0, 0, 0));
    vecs.push_back(q(3'b111, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0));
    vecs.push_back(q(3'b000, 0));
    // jump with two flush cycles
    vecs.push_back(mk(0, 1, 32'h100, 0, 0, 0, 0, 0,
                      3'b111, 1, 32'h100, 0, 0, 0));
    vecs.push_back(q(3'b111, 1));
    vecs.push_back(q(3'b000, 0));
    // jump beats int and div; int served afterwards
    vecs.push_back(mk(0, 1, 32'h200, 1, 0, 0, 1, 32'h80,
                      3'b111, 1, 32'h200, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h80,
                      3'b111, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h80,
                      3'b111, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h300, 1, 0, 1, 1, 32'h80,
                      3'b111, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h80,
                      3'b111, 1, 32'h80, 1, 0, 1));
    vecs.push_back(q(3'b111, 1));
    vecs.push_back(q(3'b000, 0));
    // divide, ready 5 cycles later; ex jump ignored while waiting
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 3'b111, 0, 0, 0, 0, 0));
    vecs.push_back(q(3'b111, 1));
    vecs.push_back(mk(0, 1, 32'h400, 0, 0, 0, 0, 0,
                      3'b111, 0, 0, 0, 0, 1));
    vecs.push_back(q(3'b111, 1));
    vecs.push_back(q(3'b111, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 3'b111, 0, 0, 0, 0, 1));
    vecs.push_back(q(3'b000, 0));
    // start and ready together: no wait state
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 3'b111, 0, 0, 0, 0, 0));
    vecs.push_back(q(3'b000, 0));
    // bus stall in IDLE, then during DIV_WAIT
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 3'b011, 0, 0, 0, 0, 0));
    vecs.push_back(q(3'b000, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 3'b111, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 3'b111, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 3'b111, 0, 0, 0, 0, 1));
    vecs.push_back(q(3'b000, 0));
    // timeout on the 64th wait cycle
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 3'b111, 0, 0, 0, 0, 0));
    for (int k = 0; k < 64; k++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,
                        3'b111, 0, 0, 0, (k == 63), 1));
    vecs.push_back(q(3'b000, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      v = vecs[i];
      drive(v);
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      check_row(i, e);
    end

    // interrupt from IDLE: ack must come INT_DRAIN cycles later
    @(posedge clk);
    #1;
    drive(mk(0, 0, 0, 0, 0, 0, 1, 32'h44, 0, 0, 0, 0, 0, 0));
    n    = 0;
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (int_ack === 1'b1) begin
        seen = 1;
        n    = c;
        chk("int_jump_addr", jump_addr, 32'h44);
        chk("int_jump_flag", {31'b0, jump_flag}, 32'd1);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    chk("int_ack_seen", {31'b0, seen}, 32'd1);
    chk("int_ack_latency", n, 32'd2);
    @(posedge clk);
    #1;
    int_req = 1'b0;
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (busy === 1'b0) seen = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("int_busy_drop", {31'b0, seen}, 32'd1);
    chk("int_hold_done", {29'b0, hold_flag}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
